// File: rtl/bta_pkg.sv
`default_nettype none
// ============================================================================
// Module : bta_pkg
// Types, header field offsets and parameter defaults for burst_to_apb.
// Rev    : 1.0 - initial release
// ============================================================================
package bta_pkg;

    localparam int c_addr_w_dflt  = 16;
    localparam int c_data_w_dflt  = 32;
    localparam int c_tmo_cyc_dflt = 16;

    localparam int c_hdr_write_bit = 31;
    localparam int c_hdr_len_msb   = 23;
    localparam int c_hdr_len_lsb   = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bta_skid.sv
`default_nettype none
// ============================================================================
// Module : bta_skid
// Two-entry read-return skid buffer holding {last, data}.
// Rev    : 1.0 - initial release
// ============================================================================
module bta_skid #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_push_last,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    input  logic              i_ready
);

    logic [DATA_W:0] r_mem [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;
    logic            w_pop;

    assign w_pop = (r_count != 2'd0) && i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= {i_push_last, i_push_data};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(i_push) - 2'(w_pop);
        end
    end

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_valid = !o_empty;
    assign o_data  = r_mem[r_rd_ptr][DATA_W-1:0];
    assign o_last  = o_valid && r_mem[r_rd_ptr][DATA_W];

endmodule
`default_nettype wire

// File: rtl/burst_to_apb.sv
`default_nettype none
// ============================================================================
// Module : burst_to_apb
// Header-led burst stream to APB master bridge with read-return stream.
// Option : BURST_TO_APB_TIMEOUT_EN enables the PREADY timeout counter.
// Rev    : 1.0 - initial release
// ============================================================================
module burst_to_apb
    import bta_pkg::*;
#(
    parameter int ADDR_W  = c_addr_w_dflt,
    parameter int DATA_W  = c_data_w_dflt,
    parameter int TMO_CYC = c_tmo_cyc_dflt
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              burst_valid,
    input  logic [DATA_W-1:0] data_burst_in,
    input  logic              burst_last,
    output logic              burst_ready,
    output logic              db_valid,
    output logic [DATA_W-1:0] data_burst_out,
    output logic              db_last,
    input  logic              db_ready,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              err,
    input  logic              err_clr,
    output logic              idle
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_err;
    logic              r_last_seen;

    logic              w_acc;
    logic              w_hdr_write;
    logic              w_hdr_err;
    logic              w_beat_final;
    logic              w_beat_err;
    logic              w_done;
    logic              w_tmo;
    logic              w_stall;
    logic              w_push;
    logic              w_err_set;
    logic [DATA_W-1:0] w_rdata;
    logic              w_skid_full;
    logic              w_skid_empty;

    assign w_acc        = burst_valid && burst_ready;
    assign w_hdr_write  = data_burst_in[c_hdr_write_bit];
    assign w_hdr_err    = w_hdr_write ? burst_last : !burst_last;
    assign w_beat_final = (r_cnt == 8'd0);
    assign w_beat_err   = (burst_last != w_beat_final);
    // A read may only start its SETUP when the return buffer can take its data.
    assign w_stall      = !r_pwrite && w_skid_full;
    assign w_push       = (r_state == ST_ACCESS) && w_done && !r_pwrite;

`ifdef BURST_TO_APB_TIMEOUT_EN
    localparam int c_tmo_w = $clog2(TMO_CYC + 1);
    logic [c_tmo_w-1:0] r_tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
        end else if ((r_state == ST_ACCESS) && !w_done) begin
            r_tmo <= r_tmo + c_tmo_w'(1);
        end else begin
            r_tmo <= '0;
        end
    end

    assign w_tmo   = !pready && (r_tmo == c_tmo_w'(TMO_CYC - 1));
    assign w_done  = pready || w_tmo;
    assign w_rdata = pready ? prdata : '0;
`else
    assign w_tmo   = 1'b0;
    assign w_done  = pready;
    assign w_rdata = prdata;
`endif

    assign w_err_set = ((r_state == ST_IDLE)   && w_acc && w_hdr_err)
                    || ((r_state == ST_WDATA)  && w_acc && w_beat_err)
                    || ((r_state == ST_ACCESS) && pready && pslverr)
                    || ((r_state == ST_ACCESS) && w_tmo);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    if (w_hdr_err)        w_state_nxt = ST_DRAIN;
                    else if (w_hdr_write) w_state_nxt = ST_WDATA;
                    else                  w_state_nxt = ST_SETUP;
                end
            end
            ST_WDATA: begin
                if (w_acc) w_state_nxt = w_beat_err ? ST_DRAIN : ST_SETUP;
            end
            ST_SETUP: begin
                if (!w_stall) w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_done) begin
                    if (w_beat_final)  w_state_nxt = ST_IDLE;
                    else if (r_pwrite) w_state_nxt = ST_WDATA;
                    else               w_state_nxt = ST_SETUP;
                end
            end
            ST_DRAIN: begin
                // The offending beat may itself have closed the burst.
                if (r_last_seen || (w_acc && burst_last)) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        burst_ready = 1'b0;
        psel        = 1'b0;
        penable     = 1'b0;
        idle        = 1'b0;
        unique case (r_state)
            ST_IDLE:   begin burst_ready = !rst; idle = w_skid_empty; end
            ST_WDATA:  burst_ready = !rst;
            ST_SETUP:  psel = !w_stall;
            ST_ACCESS: begin psel = 1'b1; penable = 1'b1; end
            ST_DRAIN:  burst_ready = !rst && !r_last_seen;
            default:   burst_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 8'd0;
            r_addr      <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_last_seen <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        r_cnt       <= data_burst_in[c_hdr_len_msb:c_hdr_len_lsb];
                        r_addr      <= data_burst_in[ADDR_W-1:0];
                        r_pwrite    <= w_hdr_write;
                        r_last_seen <= burst_last;
                    end
                end
                ST_WDATA: begin
                    if (w_acc) begin
                        r_last_seen <= burst_last;
                        if (!w_beat_err) r_pwdata <= data_burst_in;
                    end
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        r_addr <= r_addr + ADDR_W'(4);
                        if (!w_beat_final) r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign paddr  = r_addr;
    assign pwrite = r_pwrite;
    assign pwdata = r_pwdata;
    assign err    = r_err;

    bta_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_rdata),
        .i_push_last (w_beat_final),
        .o_full      (w_skid_full),
        .o_empty     (w_skid_empty),
        .o_valid     (db_valid),
        .o_data      (data_burst_out),
        .o_last      (db_last),
        .i_ready     (db_ready)
    );

endmodule
`default_nettype wire

// File: tb/tb_burst_to_apb.sv
`default_nettype none
// ============================================================================
// Module : tb_burst_to_apb
// Self-checking bench for burst_to_apb with an APB slave and stream sink.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_burst_to_apb;

    logic        clk = 1'b0;
    logic        rst;
    logic        burst_valid;
    logic [31:0] data_burst_in;
    logic        burst_last;
    logic        burst_ready;
    logic        db_valid;
    logic [31:0] data_burst_out;
    logic        db_last;
    logic        db_ready;
    logic [15:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic        err, err_clr, idle;

    int checks = 0;
    int fails  = 0;

    bit slave_en = 1'b1, slverr_inject = 1'b0, sink_en = 1'b1, sink_rand = 1'b0;
    int max_wait = 0, wait_cnt = 0;
    logic [15:0] setup_addr;

    logic [15:0] log_addr[$], log_setup[$];
    logic        log_wr[$];
    logic [31:0] log_wdata[$], log_rdata[$], rd_vals[$], wdata_q[$];
    logic [31:0] s_data[$];
    logic        s_last[$];

    burst_to_apb #(.ADDR_W(16), .DATA_W(32), .TMO_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .burst_valid(burst_valid), .data_burst_in(data_burst_in), .burst_last(burst_last), .burst_ready(burst_ready),
        .db_valid(db_valid), .data_burst_out(data_burst_out), .db_last(db_last), .db_ready(db_ready),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .err(err), .err_clr(err_clr), .idle(idle)
    );

    always #5 clk = ~clk;

    // APB slave: random wait states, logs each completed transfer.
    always @(negedge clk) begin
        if (psel && !penable) begin
            setup_addr = paddr;
            wait_cnt   = $urandom_range(0, max_wait);
        end
        if (psel && penable && slave_en && wait_cnt == 0) begin
            pready  = 1'b1;
            pslverr = slverr_inject;
            prdata  = (rd_vals.size() > 0) ? rd_vals.pop_front() : $urandom;
            log_addr.push_back(paddr);
            log_setup.push_back(setup_addr);
            log_wr.push_back(pwrite);
            log_wdata.push_back(pwdata);
            log_rdata.push_back(prdata);
        end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
            if (psel && penable && wait_cnt > 0) wait_cnt--;
        end
    end

    // Read-return sink.
    always @(negedge clk) begin
        db_ready = sink_en && (!sink_rand || ($urandom_range(0, 3) != 0));
        if (db_valid && db_ready) begin
            s_data.push_back(data_burst_out);
            s_last.push_back(db_last);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        log_addr.delete(); log_setup.delete(); log_wr.delete();
        log_wdata.delete(); log_rdata.delete(); s_data.delete(); s_last.delete();
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int  n;
        logic acc;
        n = 0;
        acc = 1'b0;
        burst_valid = 1'b1; data_burst_in = d; burst_last = l;
        while (!acc && n < 200) begin
            acc = burst_ready;
            @(negedge clk);
            n++;
        end
        burst_valid = 1'b0; burst_last = 1'b0;
        if (!acc) begin
            checks++; fails++;
            $display("FAIL beat_accept: beat %h never accepted (got ready=0, need 1)", d);
        end
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int n;
        n = 0;
        while (idle !== 1'b1 && n < bound) begin @(negedge clk); n++; end
        checks++;
        if (idle !== 1'b1) begin fails++; $display("FAIL %s_idle: got %b need 1", tag, idle); end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    endtask

    // Reference: transfers at addr+4*i (16-bit wrap), write data in order,
    // read stream equals returned prdata in order with last on the final beat.
    task automatic run_burst(input bit wr, input int len, input logic [15:0] addr,
                             input bit exp_err, input string tag);
        logic [31:0] hdr, d;
        logic [31:0] wd[$];
        logic [15:0] a;
        clear_logs();
        hdr = {wr, 7'd0, 8'(len - 1), addr};
        send_beat(hdr, !wr);
        if (wr) begin
            for (int i = 0; i < len; i++) begin
                d = (wdata_q.size() > 0) ? wdata_q.pop_front() : $urandom;
                wd.push_back(d);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_beat(d, i == len - 1);
            end
        end
        wait_idle(2000, tag);
        checks++;
        if (log_addr.size() != len) begin
            fails++; $display("FAIL %s_count: got %0d transfers need %0d", tag, log_addr.size(), len);
        end
        for (int i = 0; i < len && i < log_addr.size(); i++) begin
            a = addr + 16'(4 * i);
            checks++;
            if (log_addr[i] !== a) begin fails++; $display("FAIL %s_addr[%0d]: got %h need %h", tag, i, log_addr[i], a); end
            checks++;
            if (log_setup[i] !== a) begin fails++; $display("FAIL %s_setup_addr[%0d]: got %h need %h", tag, i, log_setup[i], a); end
            checks++;
            if (log_wr[i] !== wr) begin fails++; $display("FAIL %s_pwrite[%0d]: got %b need %b", tag, i, log_wr[i], wr); end
            if (wr) begin
                checks++;
                if (log_wdata[i] !== wd[i]) begin fails++; $display("FAIL %s_wdata[%0d]: got %h need %h", tag, i, log_wdata[i], wd[i]); end
            end
        end
        if (!wr) begin
            checks++;
            if (s_data.size() != len) begin fails++; $display("FAIL %s_stream_len: got %0d need %0d", tag, s_data.size(), len); end
            for (int i = 0; i < s_data.size() && i < log_rdata.size(); i++) begin
                checks++;
                if (s_data[i] !== log_rdata[i] || s_last[i] !== (i == len - 1)) begin
                    fails++;
                    $display("FAIL %s_stream[%0d]: got %h/%b need %h/%b", tag, i, s_data[i], s_last[i], log_rdata[i], (i == len - 1));
                end
            end
        end
        checks++;
        if (err !== exp_err) begin fails++; $display("FAIL %s_err: got %b need %b", tag, err, exp_err); end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (psel !== 1'b0)           begin fails++; $display("FAIL rst_psel: got %b need 0", psel); end
        checks++; if (penable !== 1'b0)        begin fails++; $display("FAIL rst_penable: got %b need 0", penable); end
        checks++; if (pwrite !== 1'b0)         begin fails++; $display("FAIL rst_pwrite: got %b need 0", pwrite); end
        checks++; if (paddr !== 16'h0)         begin fails++; $display("FAIL rst_paddr: got %h need 0", paddr); end
        checks++; if (pwdata !== 32'h0)        begin fails++; $display("FAIL rst_pwdata: got %h need 0", pwdata); end
        checks++; if (burst_ready !== 1'b0)    begin fails++; $display("FAIL rst_burst_ready: got %b need 0", burst_ready); end
        checks++; if (db_valid !== 1'b0)       begin fails++; $display("FAIL rst_db_valid: got %b need 0", db_valid); end
        checks++; if (db_last !== 1'b0)        begin fails++; $display("FAIL rst_db_last: got %b need 0", db_last); end
        checks++; if (data_burst_out !== 32'h0) begin fails++; $display("FAIL rst_dout: got %h need 0", data_burst_out); end
        checks++; if (err !== 1'b0)            begin fails++; $display("FAIL rst_err: got %b need 0", err); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (idle !== 1'b1)        begin fails++; $display("FAIL rel_idle: got %b need 1", idle); end
        checks++; if (burst_ready !== 1'b1) begin fails++; $display("FAIL rel_burst_ready: got %b need 1", burst_ready); end
    endtask

    task automatic test_write_directed();
        wdata_q = '{32'hA, 32'hB};
        run_burst(1'b1, 2, 16'h0100, 1'b0, "wr_directed");
    endtask

    task automatic test_read_wrap();
        rd_vals = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_burst(1'b0, 4, 16'hFFF8, 1'b0, "rd_wrap");
        if (log_addr.size() == 4) begin
            checks++;
            if (log_addr[2] !== 16'h0000) begin fails++; $display("FAIL rd_wrap_addr2: got %h need 0000", log_addr[2]); end
        end
        if (s_data.size() == 4) begin
            checks++;
            if (s_data[3] !== 32'd4 || s_last[3] !== 1'b1) begin
                fails++; $display("FAIL rd_wrap_final: got %h/%b need 4/1", s_data[3], s_last[3]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_logs();
        sink_en = 1'b0;
        send_beat(32'h0003_0040, 1'b1);
        repeat (40) @(negedge clk);
        checks++; if (log_addr.size() != 2) begin fails++; $display("FAIL bp_reads_held: got %0d need 2", log_addr.size()); end
        checks++; if (psel !== 1'b0)        begin fails++; $display("FAIL bp_psel: got %b need 0", psel); end
        checks++; if (db_valid !== 1'b1)    begin fails++; $display("FAIL bp_db_valid: got %b need 1", db_valid); end
        sink_en = 1'b1;
        wait_idle(500, "bp");
        checks++; if (log_addr.size() != 4) begin fails++; $display("FAIL bp_reads_total: got %0d need 4", log_addr.size()); end
        checks++; if (s_data.size() != 4)   begin fails++; $display("FAIL bp_stream_len: got %0d need 4", s_data.size()); end
        for (int i = 0; i < s_data.size() && i < log_rdata.size(); i++) begin
            checks++;
            if (s_data[i] !== log_rdata[i] || s_last[i] !== (i == 3)) begin
                fails++; $display("FAIL bp_stream[%0d]: got %h/%b need %h/%b", i, s_data[i], s_last[i], log_rdata[i], (i == 3));
            end
        end
    endtask

    task automatic test_protocol_errors();
        clear_logs();
        send_beat(32'h8001_0200, 1'b0);
        send_beat(32'h0000_0055, 1'b1);
        wait_idle(50, "early_last");
        checks++; if (err !== 1'b1)          begin fails++; $display("FAIL early_last_err: got %b need 1", err); end
        checks++; if (log_addr.size() > 1)   begin fails++; $display("FAIL early_last_xfers: got %0d need <=1", log_addr.size()); end
        pulse_clr();
        checks++; if (err !== 1'b0)          begin fails++; $display("FAIL err_clear: got %b need 0", err); end
        // Write header flagged last: error, and the next burst must still run.
        clear_logs();
        send_beat(32'h8000_0300, 1'b1);
        wait_idle(50, "wr_hdr_last");
        checks++; if (err !== 1'b1)          begin fails++; $display("FAIL wr_hdr_last_err: got %b need 1", err); end
        run_burst(1'b1, 1, 16'h0300, 1'b1, "after_hdr_err");
        pulse_clr();
        // Clear together with a new error: the error must win.
        clear_logs();
        err_clr = 1'b1;
        send_beat(32'h0000_0400, 1'b0);
        err_clr = 1'b0;
        checks++; if (err !== 1'b1)          begin fails++; $display("FAIL set_wins: got %b need 1", err); end
        send_beat(32'h0000_1234, 1'b0);
        send_beat(32'h0000_5678, 1'b1);
        wait_idle(50, "drain");
        checks++; if (log_addr.size() != 0)  begin fails++; $display("FAIL drain_xfers: got %0d need 0", log_addr.size()); end
        pulse_clr();
    endtask

    task automatic test_slverr();
        slverr_inject = 1'b1;
        run_burst(1'b1, 3, 16'h2000, 1'b1, "slverr");
        slverr_inject = 1'b0;
        pulse_clr();
    endtask

    task automatic test_random();
        bit wr;
        int len;
        max_wait  = 2;
        sink_rand = 1'b1;
        for (int b = 0; b < 25; b++) begin
            wr  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 6);
            run_burst(wr, len, 16'($urandom), 1'b0, "rand");
        end
        max_wait  = 0;
        sink_rand = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        clear_logs();
        slave_en = 1'b0;
        send_beat(32'h8000_0600, 1'b0);
        send_beat(32'h0000_0077, 1'b1);
        n = 0;
        while (penable !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++; if (penable !== 1'b1) begin fails++; $display("FAIL tmo_access: got %b need 1", penable); end
        repeat (20) @(negedge clk);
`ifdef BURST_TO_APB_TIMEOUT_EN
        checks++; if (err !== 1'b1)  begin fails++; $display("FAIL tmo_err: got %b need 1", err); end
        checks++; if (idle !== 1'b1) begin fails++; $display("FAIL tmo_idle: got %b need 1", idle); end
`else
        checks++; if (psel !== 1'b1 || penable !== 1'b1) begin
            fails++; $display("FAIL tmo_wait: got psel/penable %b%b need 11", psel, penable);
        end
        checks++; if (err !== 1'b0)  begin fails++; $display("FAIL tmo_err: got %b need 0", err); end
`endif
        slave_en = 1'b1;
        wait_idle(50, "tmo");
        pulse_clr();
    endtask

    task automatic test_reset_mid();
        int n;
        clear_logs();
        slave_en = 1'b0;
        send_beat(32'h8000_0700, 1'b0);
        send_beat(32'h0000_0099, 1'b1);
        n = 0;
        while (penable !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        #2 rst = 1'b1;
        #1;
        checks++; if (psel !== 1'b0 || penable !== 1'b0) begin
            fails++; $display("FAIL mid_rst_apb: got psel/penable %b%b need 00", psel, penable);
        end
        checks++; if (paddr !== 16'h0) begin fails++; $display("FAIL mid_rst_paddr: got %h need 0", paddr); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        slave_en = 1'b1;
        @(negedge clk);
        wdata_q = '{32'hCAFE_0001};
        run_burst(1'b1, 1, 16'h0800, 1'b0, "post_rst");
    endtask

    initial begin
        rst = 1'b1;
        burst_valid = 1'b0; data_burst_in = '0; burst_last = 1'b0; err_clr = 1'b0;
        test_reset();
        test_write_directed();
        test_read_wrap();
        test_backpressure();
        test_protocol_errors();
        test_slverr();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
